count_ip_mc: RTL

COUNT_IP_MC -- requirements
Module: count_ip_mc

---
 rtl/count_ip_mc_if.sv | 49 ++++
 rtl/count_ip_mc.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_ip_mc_if.sv
// AXI4-Lite bus bundle for the count_ip_mc event counter block.
// slave modport is used by the counter block, master by whatever drives it.
interface count_ip_mc_if #(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [31:0]       S_AXI_WDATA;
    logic [3:0]        S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [31:0]       S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/count_ip_mc.sv
// count_ip_mc: multi-channel event counter with an AXI4-Lite register file.
// Each ev_in bit is synchronised, rising-edge detected and counted when enabled.
// Optional interrupt logic is built when COUNT_IP_MC_IRQ_EN is defined;
// otherwise irq is tied low and IRQ_MASK reads zero.
//
// Bus-side FSMs (write and read run independently):
//   state  | meaning
//   W_IDLE | waiting for AWVALID and WVALID together; accept pulses AW/W ready
//   W_RESP | BVALID held with registered BRESP until BREADY
//   R_IDLE | waiting for ARVALID; accept pulses ARREADY, RDATA/RRESP captured
//   R_DATA | RVALID held with stable RDATA/RRESP until RREADY
module count_ip_mc #(
    parameter int NUM_CH             = 4,
    parameter int CNT_W              = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [NUM_CH-1:0] ev_in,
    count_ip_mc_if.slave      s_axi,
    output logic              irq
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    wr_state_t wr_state, wr_state_nxt;
    rd_state_t rd_state, rd_state_nxt;

    logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
    logic wr_fire, rd_fire;

    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [31:0] wa, ra;

    logic [NUM_CH-1:0] ctrl, ovf, irq_mask;
    logic [CNT_W-1:0]  cnt  [NUM_CH];
    logic [CNT_W-1:0]  snap [NUM_CH];

    logic [NUM_CH-1:0] ev_s1, ev_s2, ev_s3;
    logic [NUM_CH-1:0] ev_rise, inc, wrap, clr_vec, ovf_w1c;
    logic              snap_req;

    logic        hit_ctrl, hit_clr, hit_ovf, hit_snap, hit_mask, hit_ro, wr_ok;
    logic [31:0] wmask, ctrl_merge, mask_merge;

    logic [31:0] rd_word;
    logic        rd_ok;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q, bresp_q;

    assign aw_addr = s_axi.S_AXI_AWADDR;
    assign ar_addr = s_axi.S_AXI_ARADDR;

    // Write channel state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) wr_state <= W_IDLE;
        else        wr_state <= wr_state_nxt;
    end

    // Write channel next state and handshake outputs; ready is suppressed in reset
    always_comb begin
        wr_state_nxt = wr_state;
        aw_rdy       = 1'b0;
        w_rdy        = 1'b0;
        b_vld        = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !ARESET) begin
                    aw_rdy       = 1'b1;
                    w_rdy        = 1'b1;
                    wr_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                b_vld = 1'b1;
                if (s_axi.S_AXI_BREADY) wr_state_nxt = W_IDLE;
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Read channel state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) rd_state <= R_IDLE;
        else        rd_state <= rd_state_nxt;
    end

    // Read channel next state and handshake outputs
    always_comb begin
        rd_state_nxt = rd_state;
        ar_rdy       = 1'b0;
        r_vld        = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (s_axi.S_AXI_ARVALID && !ARESET) begin
                    ar_rdy       = 1'b1;
                    rd_state_nxt = R_DATA;
                end
            end
            R_DATA: begin
                r_vld = 1'b1;
                if (s_axi.S_AXI_RREADY) rd_state_nxt = R_IDLE;
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    assign wr_fire = aw_rdy;
    assign rd_fire = ar_rdy;

    assign s_axi.S_AXI_AWREADY = aw_rdy;
    assign s_axi.S_AXI_WREADY  = w_rdy;
    assign s_axi.S_AXI_BVALID  = b_vld;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = ar_rdy;
    assign s_axi.S_AXI_RVALID  = r_vld;
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;

    // Write address decode and byte-lane merge for the RW registers
    always_comb begin
        wa       = 32'(aw_addr);
        hit_ctrl = (wa == 32'h00);
        hit_clr  = (wa == 32'h04);
        hit_ovf  = (wa == 32'h08);
        hit_snap = (wa == 32'h0C);
        hit_mask = (wa == 32'h10);
        hit_ro   = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (wa == 32'h20 + 32'(ch * 4) || wa == 32'h40 + 32'(ch * 4)) hit_ro = 1'b1;
        end
        wr_ok = hit_ctrl | hit_clr | hit_ovf | hit_snap | hit_mask | hit_ro;

        wmask = {{8{s_axi.S_AXI_WSTRB[3]}}, {8{s_axi.S_AXI_WSTRB[2]}},
                 {8{s_axi.S_AXI_WSTRB[1]}}, {8{s_axi.S_AXI_WSTRB[0]}}};
        ctrl_merge = ({{(32-NUM_CH){1'b0}}, ctrl} & ~wmask) | (s_axi.S_AXI_WDATA & wmask);
        mask_merge = ({{(32-NUM_CH){1'b0}}, irq_mask} & ~wmask) | (s_axi.S_AXI_WDATA & wmask);

        clr_vec  = (wr_fire && hit_clr) ? s_axi.S_AXI_WDATA[NUM_CH-1:0] : '0;
        ovf_w1c  = (wr_fire && hit_ovf) ? s_axi.S_AXI_WDATA[NUM_CH-1:0] : '0;
        snap_req = wr_fire && hit_snap;
    end

    // Write response code captured at acceptance
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)       bresp_q <= RESP_OKAY;
        else if (wr_fire) bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end

    // Channel enable register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)                   ctrl <= '0;
        else if (wr_fire && hit_ctrl) ctrl <= ctrl_merge[NUM_CH-1:0];
    end

    // Event synchroniser and rising-edge detect; third flop holds previous level
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ev_s1 <= '0;
            ev_s2 <= '0;
            ev_s3 <= '0;
        end else begin
            ev_s1 <= ev_in;
            ev_s2 <= ev_s1;
            ev_s3 <= ev_s2;
        end
    end

    // Increment qualification; a wrap only counts when CLR is not overriding it
    always_comb begin
        ev_rise = ev_s2 & ~ev_s3;
        inc     = ev_rise & ctrl;
        wrap    = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wrap[ch] = inc[ch] && !clr_vec[ch] && (cnt[ch] == CNT_MAX);
        end
    end

    // Counters and snapshots; CLR beats increment, snapshot sees pre-increment value
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt[ch]  <= '0;
                snap[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (clr_vec[ch])  cnt[ch] <= '0;
                else if (inc[ch]) cnt[ch] <= cnt[ch] + CNT_ONE;
                if (snap_req)     snap[ch] <= cnt[ch];
            end
        end
    end

    // Sticky overflow flags; a new wrap wins over a simultaneous W1C
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) ovf <= '0;
        else        ovf <= (ovf & ~ovf_w1c) | wrap;
    end

`ifdef COUNT_IP_MC_IRQ_EN
    // Interrupt mask register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)                   irq_mask <= '0;
        else if (wr_fire && hit_mask) irq_mask <= mask_merge[NUM_CH-1:0];
    end

    // Registered interrupt level, one cycle behind the overflow flags
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) irq <= 1'b0;
        else        irq <= |(ovf & irq_mask);
    end
`else
    logic unused_mask_merge;
    assign unused_mask_merge = ^mask_merge;
    assign irq_mask = '0;
    assign irq      = 1'b0;
`endif

    // Read address decode and data mux; counts zero-extend to 32 bits
    always_comb begin
        ra      = 32'(ar_addr);
        rd_word = 32'h0;
        rd_ok   = 1'b0;
        case (ra)
            32'h00: begin rd_ok = 1'b1; rd_word = 32'(ctrl);     end
            32'h04: begin rd_ok = 1'b1; rd_word = 32'h0;         end
            32'h08: begin rd_ok = 1'b1; rd_word = 32'(ovf);      end
            32'h0C: begin rd_ok = 1'b1; rd_word = 32'h0;         end
            32'h10: begin rd_ok = 1'b1; rd_word = 32'(irq_mask); end
            default: begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (ra == 32'h20 + 32'(ch * 4)) begin
                        rd_ok   = 1'b1;
                        rd_word = 32'(cnt[ch]);
                    end
                    if (ra == 32'h40 + 32'(ch * 4)) begin
                        rd_ok   = 1'b1;
                        rd_word = 32'(snap[ch]);
                    end
                end
            end
        endcase
    end

    // Read data and response captured at acceptance, held while RVALID is up
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rdata_q <= 32'h0;
            rresp_q <= RESP_OKAY;
        end else if (rd_fire) begin
            rdata_q <= rd_ok ? rd_word : 32'h0;
            rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end
endmodule
